mux_41: RTL and testbench
=========================

// Module: mux_41
// PURPOSE
//   Registered 4-to-1 multiplexer for WIDTH-bit data words. Each cycle it
//   selects one of four operands (i0..i3) with a 2-bit select and registers it.
//   Generic datapath steering element used by the sort/compare datapath to
//   route one of four candidate values to a single consumer.
// PARAMETERS
//   WIDTH     16   data width of each input operand and the output
// PORTS
//   clk        in   1      rising-edge clock; single clock domain
//   rst        in   1      synchronous, active-high reset
//   en         in   1      capture enable; 1 = register selected input this edge
//   i0         in   WIDTH  operand selected when sel = 2'd0
//   i1         in   WIDTH  operand selected when sel = 2'd1
//   i2         in   WIDTH  operand selected when sel = 2'd2
//   i3         in   WIDTH  operand selected when sel = 2'd3
//   sel        in   2      operand select, binary encoded
//   out        out  WIDTH  registered selected operand
//   out_valid  out  1      1 = out holds a value captured since last reset
// BEHAVIOUR
//   - One clock (clk) and one reset (rst). Reset is synchronous and
//     active-high: sampled only on the rising clk edge.
//   - Reset: on an edge with rst=1, out <= {WIDTH{1'b0}} and out_valid <= 0.
//     rst has priority over en. A reset in mid-stream discards any pending
//     capture on that edge.
//   - Capture: on an edge with rst=0 and en=1, out <= operand selected by sel
//     (0->i0, 1->i1, 2->i2, 3->i3). out_valid <= 1.
//   - Hold: on an edge with rst=0 and en=0, out and out_valid keep their
//     values.
//   - Latency: exactly one cycle. The inputs and sel sampled at edge N appear
//     on out after edge N. out has no combinational path from inputs or sel.
//   - Select decode is full: all four codes are legal, with no default/illegal
//     state. A sel bit that is X/Z in simulation must not be masked: out
//     propagates X, and there is no silent fallback to i0.
//   - Operands and sel may all change in the same cycle. The value captured is
//     the one present at the edge.
//   - Data passes through bit-exact: no sign extension, truncation or
//     arithmetic. All-zeros and all-ones words pass unchanged.
//   - out_valid stays 1 until the next reset; it is not a per-cycle strobe.
//   - No state machine beyond the output register and the valid flag.
// TESTING
//   1. i0=5,i1=4,i2=89,i3=789, en=1; sel=0,1,2,3 on successive cycles ->
//      out = 5,4,89,789, each one cycle after its sel is applied.
//   2. rst=1 for 2 cycles with en=1, sel=3 -> out=0, out_valid=0. Release rst;
//      the next edge gives out=789 and out_valid=1.
//   3. Capture out=89 (sel=2), then en=0 and sel=0 with i2 changed to 7 ->
//      out stays 89 for 3 cycles.
//   4. Assert rst mid-sequence while en=1 and sel changes on the same edge ->
//      out=0, out_valid=0, and the sel value is not captured.
//   5. i1=16'hFFFF, i3=16'h0000, alternate sel=1/3 every cycle ->
//      out toggles FFFF/0000 with 1-cycle lag; no bit loss.
//   6. Change i0 and sel in the same cycle (sel: 2->0, i0: 5->1234) ->
//      out=1234 after the edge.

Source files
------------

// File: rtl/mux_41.sv
// Registered 4-to-1 multiplexer for WIDTH-bit words.
// One cycle of latency from operands/select to out. out_valid latches high on the
// first capture after reset and stays high until the next reset.
module mux_41 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;

  // Select the operand. This uses a ternary tree rather than a case with a default.
  // An X/Z select bit then yields X on every bit where the candidates differ. It
  // does not fall back silently to i0.
  always_comb begin
    sel_data = sel[1] ? (sel[0] ? i3 : i2) : (sel[0] ? i1 : i0);
  end

  // Next-state logic. Reset has priority over capture; with en low, state holds.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (rst) begin
      out_d   = '0;
      valid_d = 1'b0;
    end else if (en) begin
      out_d   = sel_data;
      valid_d = 1'b1;
    end
  end

  // Output and valid registers. Reset is synchronous: it is applied through out_d/valid_d.
  always_ff @(posedge clk) begin
    out_q   <= out_d;
    valid_q <= valid_d;
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_41.sv
// Bench for mux_41. It runs directed scenarios followed by random traffic.
// Every check compares the DUT against an operand-array reference model.
module tb_mux_41;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] i0, i1, i2, i3;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic [WIDTH-1:0] m_out;
  logic             m_valid;
  logic [WIDTH-1:0] ops [4];

  mux_41 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .i0        (i0),
    .i1        (i1),
    .i2        (i2),
    .i3        (i3),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (out === exp) else begin
      n_err++;
      $error("FAIL %s: out observed %h expected %h", tag, out, exp);
    end
  endtask

  task automatic check_valid(input string tag, input logic exp);
    n_cmp++;
    assert (out_valid === exp) else begin
      n_err++;
      $error("FAIL %s: out_valid observed %b expected %b", tag, out_valid, exp);
    end
  endtask

  // Advance one edge. The model samples the inputs present at that edge.
  // Outputs are checked 1 time unit after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    ops = '{i0, i1, i2, i3};
    if (rst) begin
      m_out   = '0;
      m_valid = 1'b0;
    end else if (en) begin
      m_out   = ops[sel];
      m_valid = 1'b1;
    end
    #1;
    check_out(tag, m_out);
    check_valid(tag, m_valid);
  endtask

  initial begin
    m_out = '0; m_valid = 1'b0;
    rst = 1'b1; en = 1'b0; sel = 2'd0;
    i0 = '0; i1 = '0; i2 = '0; i3 = '0;
    #2;
    tick("reset0");
    tick("reset1");
    check_out("reset_const", 16'd0);

    // 1: walk sel 0..3
    rst = 1'b0; en = 1'b1;
    i0 = 16'd5; i1 = 16'd4; i2 = 16'd89; i3 = 16'd789;
    sel = 2'd0; tick("t1_s0"); check_out("t1_s0_const", 16'd5);
    sel = 2'd1; tick("t1_s1"); check_out("t1_s1_const", 16'd4);
    sel = 2'd2; tick("t1_s2"); check_out("t1_s2_const", 16'd89);
    sel = 2'd3; tick("t1_s3"); check_out("t1_s3_const", 16'd789);

    // 2: reset held with en=1, then released
    rst = 1'b1; sel = 2'd3;
    tick("t2_rst0");
    tick("t2_rst1"); check_out("t2_rst_const", 16'd0); check_valid("t2_rst_v", 1'b0);
    rst = 1'b0;
    tick("t2_rel"); check_out("t2_rel_const", 16'd789); check_valid("t2_rel_v", 1'b1);

    // 3: hold with en=0
    sel = 2'd2; tick("t3_cap"); check_out("t3_cap_const", 16'd89);
    en = 1'b0; sel = 2'd0; i2 = 16'd7;
    for (int k = 0; k < 3; k++) begin
      tick("t3_hold"); check_out("t3_hold_const", 16'd89);
    end

    // 4: reset on the same edge as a sel change discards the capture
    en = 1'b1; sel = 2'd1; tick("t4_pre");
    rst = 1'b1; sel = 2'd3; tick("t4_rst");
    check_out("t4_rst_const", 16'd0); check_valid("t4_rst_v", 1'b0);
    rst = 1'b0;

    // 5: all-ones / all-zeros toggling
    i1 = 16'hFFFF; i3 = 16'h0000;
    for (int k = 0; k < 6; k++) begin
      sel = (k % 2 == 0) ? 2'd1 : 2'd3;
      tick("t5_toggle");
      check_out("t5_const", (k % 2 == 0) ? 16'hFFFF : 16'h0000);
    end

    // 6: operand and sel change together
    i0 = 16'd5; sel = 2'd2; tick("t6_pre");
    i0 = 16'd1234; sel = 2'd0; tick("t6_same"); check_out("t6_const", 16'd1234);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(15) == 0);
      en  = $urandom_range(1);
      sel = 2'($urandom_range(3));
      i0  = WIDTH'($urandom);
      i1  = WIDTH'($urandom);
      i2  = WIDTH'($urandom);
      i3  = WIDTH'($urandom);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
